// File: rtl/uart_mem_loader.sv
// uart_mem_loader: receives a framed image over UART (8N1), writes it
// word-by-word to IMEM/DMEM and then releases the CPU from reset.
// Frame: A5, N_lo, N_hi, 4*N data bytes (LE words) [, checksum].
// Define LOADER_CHECKSUM_EN to send and verify the trailing checksum.
// Ports: clk, rst (async, active-low), serial_in (UART RX),
//   mem_we/mem_addr/mem_din (write port), cpu_rst (active-high),
//   load_done (sticky), load_error (sticky until next sync byte).
module uart_mem_loader #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int unsigned CAP = 32'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_t;

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE
  } st_t;

  // ---------------- UART receiver ----------------
  logic          s1, s2, s3;
  rx_t           rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;

  // s3 is the previous synchronised sample, used for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      rx_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s1     <= serial_in;
      s2     <= s1;
      s3     <= s2;
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      vld_q  <= vld_d;
      ferr_q <= ferr_d;
    end
  end

  always_comb begin
    rx_d   = rx_q;
    cnt_d  = cnt_q + 1'b1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (s3 && !s2) rx_d = RX_START;
      end
      RX_START: begin
        // line high at mid start bit: treat as glitch
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          sh_d  = {s2, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d  = '0;
          rx_d   = RX_IDLE;
          vld_d  = s2;
          ferr_d = !s2;
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // ---------------- Frame loader ----------------
  st_t         st_q, st_d;
  logic [7:0]  nlo_q, nlo_d;
  logic [15:0] n_q, n_d;
  logic [15:0] widx_q, widx_d;
  logic [1:0]  bsel_q, bsel_d;
  logic [23:0] wsh_q, wsh_d;
  logic        we_d, done_d, err_d, crst_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0] din_d;
  logic [15:0] n_new;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  assign n_new = {sh_q, nlo_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= IDLE;
      nlo_q      <= '0;
      n_q        <= '0;
      widx_q     <= '0;
      bsel_q     <= '0;
      wsh_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      cpu_rst    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      st_q       <= st_d;
      nlo_q      <= nlo_d;
      n_q        <= n_d;
      widx_q     <= widx_d;
      bsel_q     <= bsel_d;
      wsh_q      <= wsh_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_din    <= din_d;
      load_done  <= done_d;
      load_error <= err_d;
      cpu_rst    <= crst_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  always_comb begin
    st_d   = st_q;
    nlo_d  = nlo_q;
    n_d    = n_q;
    widx_d = widx_q;
    bsel_d = bsel_q;
    wsh_d  = wsh_q;
    we_d   = 1'b0;
    addr_d = mem_addr;
    din_d  = mem_din;
    done_d = load_done;
    err_d  = load_error;
    crst_d = cpu_rst;
`ifdef LOADER_CHECKSUM_EN
    sum_d  = sum_q;
`endif
    // DONE is terminal: the CPU is already running
    if (ferr_q && st_q != DONE) begin
      err_d = 1'b1;
      st_d  = IDLE;
    end else if (vld_q) begin
      unique case (st_q)
        IDLE: begin
          if (sh_q == 8'hA5) begin
            st_d  = CNT_LO;
            err_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_d = '0;
`endif
          end
        end
        CNT_LO: begin
          nlo_d = sh_q;
          st_d  = CNT_HI;
        end
        CNT_HI: begin
          n_d    = n_new;
          widx_d = '0;
          bsel_d = '0;
          if (32'(n_new) > CAP) begin
            err_d = 1'b1;
            st_d  = IDLE;
          end else if (n_new == '0) begin
`ifdef LOADER_CHECKSUM_EN
            st_d   = CHECK;
`else
            st_d   = DONE;
            done_d = 1'b1;
            crst_d = 1'b0;
`endif
          end else begin
            st_d = DATA;
          end
        end
        DATA: begin
          wsh_d  = {sh_q, wsh_q[23:8]};
          bsel_d = bsel_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + sh_q;
`endif
          if (bsel_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = ADDR_WIDTH'(widx_q);
            din_d  = {sh_q, wsh_q};
            widx_d = widx_q + 1'b1;
            if (17'(widx_q) + 17'd1 == 17'(n_q)) begin
`ifdef LOADER_CHECKSUM_EN
              st_d   = CHECK;
`else
              st_d   = DONE;
              done_d = 1'b1;
              crst_d = 1'b0;
`endif
            end
          end
        end
        CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (sh_q == sum_q) begin
            st_d   = DONE;
            done_d = 1'b1;
            crst_d = 1'b0;
          end else begin
            err_d = 1'b1;
            st_d  = IDLE;
          end
`else
          st_d   = DONE;
          done_d = 1'b1;
          crst_d = 1'b0;
`endif
        end
        DONE: st_d = DONE;
        default: st_d = IDLE;
      endcase
    end
  end

endmodule
